// File: rtl/sclk_fifo_lut.sv
// Single-clock FWFT FIFO on distributed memory with wrap-bit pointers.
// Optional sticky overflow/underflow flags: define SCLK_FIFO_LUT_ERR_FLAGS_EN.
module sclk_fifo_lut #(
  parameter int LOG2_FIFO_DEPTH = 3,
  parameter int FIFO_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wen,
  input  logic [FIFO_WIDTH-1:0]    wdata,
  output logic                     wfull,
  output logic [LOG2_FIFO_DEPTH:0] wlevel,
  input  logic                     ren,
  output logic [FIFO_WIDTH-1:0]    rdata,
  output logic                     rempty,
  output logic [LOG2_FIFO_DEPTH:0] rlevel
`ifdef SCLK_FIFO_LUT_ERR_FLAGS_EN
  ,
  output logic                     werr,
  output logic                     rerr
`endif
);

  localparam int DEPTH = 1 << LOG2_FIFO_DEPTH;
  localparam logic [LOG2_FIFO_DEPTH:0] PTR_ONE = {{LOG2_FIFO_DEPTH{1'b0}}, 1'b1};
  localparam logic [LOG2_FIFO_DEPTH:0] PTR_ZERO = {(LOG2_FIFO_DEPTH+1){1'b0}};

  logic [FIFO_WIDTH-1:0]    mem_r [DEPTH];
  logic [LOG2_FIFO_DEPTH:0] wptr_r;
  logic [LOG2_FIFO_DEPTH:0] rptr_r;
  logic [LOG2_FIFO_DEPTH:0] occupancy_s;
  logic                     full_s;
  logic                     empty_s;
  logic                     wr_accept_s;
  logic                     rd_accept_s;

  // Flags come from the registered pointers only, never from wen/ren.
  assign empty_s     = (wptr_r == rptr_r);
  assign full_s      = (wptr_r[LOG2_FIFO_DEPTH] != rptr_r[LOG2_FIFO_DEPTH]) &&
                       (wptr_r[LOG2_FIFO_DEPTH-1:0] == rptr_r[LOG2_FIFO_DEPTH-1:0]);
  assign occupancy_s = wptr_r - rptr_r;
  assign wr_accept_s = wen & ~full_s & ~srst;
  assign rd_accept_s = ren & ~empty_s & ~srst;

  assign rempty = empty_s;
  assign wfull  = full_s;
  assign wlevel = occupancy_s;
  assign rlevel = occupancy_s;
  assign rdata  = mem_r[rptr_r[LOG2_FIFO_DEPTH-1:0]];

  // Storage array: synchronous write, no reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wptr_r[LOG2_FIFO_DEPTH-1:0]] <= wdata;
    end
  end

  // Write and read pointers, wrapping modulo twice the depth.
  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_r <= PTR_ZERO;
      rptr_r <= PTR_ZERO;
    end else begin
      if (wr_accept_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (rd_accept_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
    end
  end

`ifdef SCLK_FIFO_LUT_ERR_FLAGS_EN
  logic werr_r;
  logic rerr_r;

  // Sticky attempt-while-full / attempt-while-empty flags.
  always_ff @(posedge clk) begin
    if (srst) begin
      werr_r <= 1'b0;
      rerr_r <= 1'b0;
    end else begin
      if (wen && full_s) begin
        werr_r <= 1'b1;
      end
      if (ren && empty_s) begin
        rerr_r <= 1'b1;
      end
    end
  end

  assign werr = werr_r;
  assign rerr = rerr_r;
`endif

endmodule

// File: tb/tb_sclk_fifo_lut.sv
// Self-checking bench for sclk_fifo_lut: directed plan plus random traffic
// against a queue model of the FIFO.
module tb_sclk_fifo_lut;

  logic       clk = 1'b0;
  logic       srst;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic       wfull;
  logic       rempty;
  logic [3:0] wlevel;
  logic [3:0] rlevel;
  logic [7:0] rdata;
`ifdef SCLK_FIFO_LUT_ERR_FLAGS_EN
  logic       werr;
  logic       rerr;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  bit         m_werr = 1'b0;
  bit         m_rerr = 1'b0;

  sclk_fifo_lut #(.LOG2_FIFO_DEPTH(3), .FIFO_WIDTH(8)) dut (
    .clk    (clk),
    .srst   (srst),
    .wen    (wen),
    .wdata  (wdata),
    .wfull  (wfull),
    .wlevel (wlevel),
    .ren    (ren),
    .rdata  (rdata),
    .rempty (rempty),
    .rlevel (rlevel)
`ifdef SCLK_FIFO_LUT_ERR_FLAGS_EN
    ,
    .werr   (werr),
    .rerr   (rerr)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rempty", {31'd0, rempty}, (q.size() == 0) ? 32'd1 : 32'd0);
    chk("wfull",  {31'd0, wfull},  (q.size() == 8) ? 32'd1 : 32'd0);
    chk("wlevel", {28'd0, wlevel}, q.size());
    chk("rlevel", {28'd0, rlevel}, q.size());
    if (q.size() != 0) chk("rdata", {24'd0, rdata}, {24'd0, q[0]});
`ifdef SCLK_FIFO_LUT_ERR_FLAGS_EN
    chk("werr", {31'd0, werr}, {31'd0, m_werr});
    chk("rerr", {31'd0, rerr}, {31'd0, m_rerr});
`endif
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic step(input bit s, input bit w, input logic [7:0] d, input bit r);
    bit full, empty;
    srst = s; wen = w; wdata = d; ren = r;
    @(posedge clk);
    if (s) begin
      q.delete();
      m_werr = 1'b0;
      m_rerr = 1'b0;
    end else begin
      full  = (q.size() == 8);
      empty = (q.size() == 0);
      if (w && full)  m_werr = 1'b1;
      if (r && empty) m_rerr = 1'b1;
      if (r && !empty) void'(q.pop_front());
      if (w && !full)  q.push_back(d);
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int nxt;
    srst = 1'b1; wen = 1'b0; wdata = 8'h00; ren = 1'b0;
    @(negedge clk);

    // 1. reset for two cycles with wen asserted
    step(1'b1, 1'b1, 8'hAA, 1'b0);
    step(1'b1, 1'b1, 8'hBB, 1'b0);
    chk("reset_level", {28'd0, wlevel}, 32'd0);

    // 2. fill 1..7, idle, then 8
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
      chk("fill_level", {28'd0, wlevel}, i);
      chk("fill_head", {24'd0, rdata}, 32'd1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'd8, 1'b0);
    chk("full_after_8", {31'd0, wfull}, 32'd1);

    // 3. overflow
    step(1'b0, 1'b1, 8'd10, 1'b0);
    chk("ovf_level", {28'd0, wlevel}, 32'd8);
    chk("ovf_head", {24'd0, rdata}, 32'd1);

    // 4. drain 7, idle, one more
    for (int i = 1; i <= 7; i++) begin
      chk("drain_data", {24'd0, rdata}, i);
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_last", {24'd0, rdata}, 32'd8);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_empty", {31'd0, rempty}, 32'd1);

    // 5. underflow, then write 0x15 and read it back
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("udf_level", {28'd0, rlevel}, 32'd0);
    step(1'b0, 1'b1, 8'h15, 1'b0);
    chk("udf_wr", {24'd0, rdata}, 32'h15);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // 6. streaming across the pointer wrap
    nxt = 21;
    for (int k = 0; k < 8; k++) begin
      if (q.size() != 0) begin
        chk("stream", {24'd0, rdata}, nxt);
        nxt++;
      end
      step(1'b0, 1'b1, 8'(21 + k), q.size() != 0);
    end
    for (int k = 0; k < 10 && q.size() != 0; k++) begin
      chk("stream", {24'd0, rdata}, nxt);
      nxt++;
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("stream_count", nxt, 32'd29);
    chk("stream_empty", {31'd0, rempty}, 32'd1);

    // 7. random traffic with occasional mid-operation reset
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 99) < 55,
           8'($urandom), $urandom_range(0, 99) < 50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
